getir: RTL

Instruction fetch stage of the in-order RV32I pipeline, directly upstream of the decoder (`cozucu`). It holds the program counter and issues word-aligned read requests to instruction memory over a valid/ready handshake. Returned instructions are buffered, with their PCs, in a 2-entry queue that the decoder drains. Branch/jump redirects from execute flush the queue and discard in-flight responses.

---
 rtl/getir_if.sv | 29 ++
 rtl/getir.sv | 119 +++++++++++
 2 files changed

// File: rtl/getir_if.sv
`default_nettype none
// ============================================================================
// getir_if : instruction-memory request/response bundle for the fetch stage
// Revision : 1.0
// ============================================================================
interface getir_if;
    logic        bellek_istek_gecerli;
    logic        bellek_istek_hazir;
    logic [31:0] bellek_adres;
    logic        bellek_yanit_gecerli;
    logic [31:0] bellek_veri;

    modport master (
        output bellek_istek_gecerli,
        output bellek_adres,
        input  bellek_istek_hazir,
        input  bellek_yanit_gecerli,
        input  bellek_veri
    );

    modport slave (
        input  bellek_istek_gecerli,
        input  bellek_adres,
        output bellek_istek_hazir,
        output bellek_yanit_gecerli,
        output bellek_veri
    );
endinterface
`default_nettype wire

// File: rtl/getir.sv
`default_nettype none
// ============================================================================
// getir    : RV32I fetch stage, PC + 2-entry {PC, instruction} queue.
//            Optional GETIR_HIZALAMA_KONTROL_EN: trap misaligned redirects.
// Revision : 1.0
// ============================================================================
module getir #(
    parameter logic [31:0] BASLANGIC_ADRESI = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    getir_if.master     bellek,
    input  logic        dallanma_i,
    input  logic [31:0] dallanma_adresi_i,
    input  logic        cozucu_hazir_i,
    output logic [31:0] buyruk_o,
    output logic [31:0] ps_o,
    output logic        buyruk_gecerli_o,
    output logic        hizalama_hatasi_o
);

    localparam logic [31:0] C_NOP = 32'h0000_0013;

    logic [31:0] r_ps;
    logic [31:0] r_yanit_ps;
    logic [31:0] r_q_ps     [0:1];
    logic [31:0] r_q_buyruk [0:1];
    logic [1:0]  r_dol;
    logic [1:0]  r_bekleyen;
    logic [1:0]  r_atilacak;
    logic        r_basladi;
    logic        r_hata;

    logic        w_pop;
    logic        w_gecerli;
    logic        w_kabul;
    logic        w_at;
    logic        w_push;
    logic        w_yaz_idx;
    logic        w_hizasiz;
    logic [2:0]  w_doluluk;
    logic [31:0] w_hedef;

`ifdef GETIR_HIZALAMA_KONTROL_EN
    assign w_hedef   = dallanma_adresi_i;
    assign w_hizasiz = (dallanma_adresi_i[1:0] != 2'b00);
`else
    assign w_hedef   = dallanma_adresi_i & ~32'h0000_0003;
    assign w_hizasiz = 1'b0;
`endif

    assign w_pop     = (r_dol != 2'd0) && cozucu_hazir_i;
    // Every slot already promised (queued, outstanding or to be dropped)
    // counts against the 2-entry queue; a pop this cycle frees one.
    assign w_doluluk = {1'b0, r_dol} + {1'b0, r_bekleyen} + {1'b0, r_atilacak}
                     - {2'b00, w_pop};
    assign w_gecerli = r_basladi && !r_hata && !dallanma_i && (w_doluluk < 3'd2);
    assign w_kabul   = w_gecerli && bellek.bellek_istek_hazir;
    assign w_at      = bellek.bellek_yanit_gecerli && (r_atilacak != 2'd0);
    assign w_push    = bellek.bellek_yanit_gecerli && (r_atilacak == 2'd0);
    // Slot for a push: after a pop shifts the head, it is dol-pop.
    assign w_yaz_idx = r_dol[0] ^ w_pop;

    assign bellek.bellek_istek_gecerli = w_gecerli;
    assign bellek.bellek_adres         = r_basladi ? r_ps : 32'h0000_0000;

    assign buyruk_gecerli_o  = (r_dol != 2'd0);
    assign buyruk_o          = buyruk_gecerli_o ? r_q_buyruk[0] : C_NOP;
    assign ps_o              = buyruk_gecerli_o ? r_q_ps[0] : 32'h0000_0000;
    assign hizalama_hatasi_o = r_hata;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_ps          <= BASLANGIC_ADRESI;
            r_yanit_ps    <= BASLANGIC_ADRESI;
            r_q_ps[0]     <= 32'h0000_0000;
            r_q_ps[1]     <= 32'h0000_0000;
            r_q_buyruk[0] <= 32'h0000_0000;
            r_q_buyruk[1] <= 32'h0000_0000;
            r_dol         <= 2'd0;
            r_bekleyen    <= 2'd0;
            r_atilacak    <= 2'd0;
            r_basladi     <= 1'b0;
            r_hata        <= 1'b0;
        end else begin
            r_basladi <= 1'b1;
            if (dallanma_i) begin
                // Whatever is still outstanding becomes a response to drop.
                r_ps       <= w_hedef;
                r_yanit_ps <= w_hedef;
                r_dol      <= 2'd0;
                r_bekleyen <= 2'd0;
                r_atilacak <= r_atilacak + r_bekleyen
                            - {1'b0, bellek.bellek_yanit_gecerli};
                r_hata     <= w_hizasiz;
            end else begin
                if (w_kabul) begin
                    r_ps <= r_ps + 32'd4;
                end
                r_bekleyen <= r_bekleyen + {1'b0, w_kabul} - {1'b0, w_push};
                if (w_at) begin
                    r_atilacak <= r_atilacak - 2'd1;
                end
                if (w_pop) begin
                    r_q_ps[0]     <= r_q_ps[1];
                    r_q_buyruk[0] <= r_q_buyruk[1];
                end
                if (w_push) begin
                    r_yanit_ps             <= r_yanit_ps + 32'd4;
                    r_q_ps[w_yaz_idx]      <= r_yanit_ps;
                    r_q_buyruk[w_yaz_idx]  <= bellek.bellek_veri;
                end
                r_dol <= r_dol + {1'b0, w_push} - {1'b0, w_pop};
            end
        end
    end

endmodule
`default_nettype wire
